// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline skid register (main + skid) with flush and optional
// stall/bubble performance counters enabled by `define PIPE_SKID_PERF_CNT_EN.
module pipe_skid_reg #(
    parameter int WIDTH = 65,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [1:0]       occupancy,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    // State encoding doubles as the occupancy count.
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;

    // Handshake outputs come straight from the state register, so neither
    // ready nor valid has a combinational path through this block.
    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign out_data  = main_q;
    assign occupancy = state;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_valid) begin
                    load_main_in = 1'b1;
                    state_nxt    = BUSY;
                end
            end
            BUSY: begin
                if (in_valid && out_ready) begin
                    load_main_in = 1'b1;
                end else if (in_valid) begin
                    load_skid = 1'b1;
                    state_nxt = FULL;
                end else if (out_ready) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (out_ready) begin
                    load_main_skid = 1'b1;
                    state_nxt      = BUSY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // A redirect drops everything held plus whatever is offered this cycle.
        if (flush) begin
            state_nxt      = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state <= state_nxt;
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

`ifdef PIPE_SKID_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] bubble_q;

    // Counters saturate at all-ones; clear wins over increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else if (clr_cnt) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
                stall_q <= stall_q + 1'b1;
            end
            if (!out_valid && out_ready && (bubble_q != {CNT_W{1'b1}})) begin
                bubble_q <= bubble_q + 1'b1;
            end
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    logic unused_clr_cnt;

    assign unused_clr_cnt = clr_cnt;
    assign stall_cnt      = '0;
    assign bubble_cnt     = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed scoreboard bench for pipe_skid_reg; counter expectations follow
// whether PIPE_SKID_PERF_CNT_EN is defined for the build.
module tb_pipe_skid_reg;

    localparam int WIDTH = 65;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             flush;
    logic [1:0]       occupancy;
    logic             clr_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    pipe_skid_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .flush      (flush),
        .occupancy  (occupancy),
        .clr_cnt    (clr_cnt),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    int               vectors     = 0;
    int               miscompares = 0;
    logic [WIDTH-1:0] sb_q[$];
    logic [CNT_W-1:0] stall_exp   = '0;
    logic [CNT_W-1:0] bubble_exp  = '0;
    bit               known       = 1'b0;

    task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs against the model, then advance the model across the edge.
    task automatic cycle(input logic r, input logic iv, input logic [WIDTH-1:0] d,
                         input logic ordy, input logic fl, input logic cl);
        logic ov_e;
        logic ir_e;
        rst_n     = r;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        clr_cnt   = cl;
        #1;
        ov_e = (sb_q.size() != 0);
        ir_e = (sb_q.size() != 2);
        if (known) begin
            check("occupancy", WIDTH'(occupancy), WIDTH'(sb_q.size()));
            check("in_ready", WIDTH'(in_ready), WIDTH'(ir_e));
            check("out_valid", WIDTH'(out_valid), WIDTH'(ov_e));
            if (ov_e) check("out_data", out_data, sb_q[0]);
            check("stall_cnt", WIDTH'(stall_cnt), WIDTH'(stall_exp));
            check("bubble_cnt", WIDTH'(bubble_cnt), WIDTH'(bubble_exp));
        end
        if (!r) begin
            sb_q.delete();
            stall_exp  = '0;
            bubble_exp = '0;
            known      = 1'b1;
        end else begin
`ifdef PIPE_SKID_PERF_CNT_EN
            if (cl) begin
                stall_exp  = '0;
                bubble_exp = '0;
            end else begin
                if (ov_e && !ordy && stall_exp != CNT_MAX) stall_exp = stall_exp + 1'b1;
                if (!ov_e && ordy && bubble_exp != CNT_MAX) bubble_exp = bubble_exp + 1'b1;
            end
`endif
            if (ov_e && ordy) void'(sb_q.pop_front());
            if (iv && ir_e) sb_q.push_back(d);
            if (fl) sb_q.delete();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [WIDTH-1:0] pay_a;
        logic [WIDTH-1:0] pay_b;
        logic [WIDTH-1:0] pay_c;
        pay_a = 65'h0_dead_beef_0000_00a0;
        pay_b = 65'h1_0bad_f00d_0000_00b0;
        pay_c = 65'h0_cafe_babe_0000_00c0;
        @(negedge clk);

        // Reset, then a single transfer right after release.
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("reset_out_data", out_data, '0);
        cycle(1'b1, 1'b1, 65'h1_0000_0013_0000_0000, 1'b1, 1'b0, 1'b0);
        check("first_xfer_occ", WIDTH'(occupancy), WIDTH'(1));
        check("first_xfer_data", out_data, 65'h1_0000_0013_0000_0000);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Back-to-back stream at full throughput.
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b1, WIDTH'(i), 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Backpressure: A and B held, C waits upstream, then drain in order.
        cycle(1'b1, 1'b1, pay_a, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, pay_b, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, pay_c, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, pay_c, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, pay_c, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, pay_c, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Long stall saturates the stall counter, then clear it.
        cycle(1'b1, 1'b1, pay_a, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_SKID_PERF_CNT_EN
        check("stall_saturated", WIDTH'(stall_cnt), WIDTH'(15));
`else
        check("stall_disabled", WIDTH'(stall_cnt), WIDTH'(0));
`endif
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        check("stall_cleared", WIDTH'(stall_cnt), WIDTH'(0));

        // Flush while FULL with C offered: nothing reaches downstream.
        cycle(1'b1, 1'b1, pay_b, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, pay_c, 1'b0, 1'b1, 1'b0);
        check("flush_occ", WIDTH'(occupancy), WIDTH'(0));
        check("flush_out_valid", WIDTH'(out_valid), WIDTH'(0));
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Reset while FULL and flushing takes priority and clears everything.
        cycle(1'b1, 1'b1, pay_a, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, pay_b, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, pay_c, 1'b1, 1'b1, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_stall_cnt", WIDTH'(stall_cnt), WIDTH'(0));
        cycle(1'b1, 1'b1, pay_c, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 65, payload width in bits (fits if_t: isValid + instr + pc).
REQ-002 SHALL have parameter CNT_W, default 16, width of each performance counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; one clock, reset is synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, upstream stage presents a valid payload.
REQ-006 SHALL have port in_ready, output, 1, block accepts in_data this cycle.
REQ-007 SHALL have port in_data, input, WIDTH, upstream payload.
REQ-008 SHALL have port out_valid, output, 1, out_data holds a valid payload.
REQ-009 SHALL have port out_ready, input, 1, downstream stage accepts out_data this cycle.
REQ-010 SHALL have port out_data, output, WIDTH, payload to downstream stage.
REQ-011 SHALL have port flush, input, 1, discard all held payloads (branch/jump redirect).
REQ-012 SHALL have port occupancy, output, 2, number of held payloads (0..2).
REQ-013 SHALL have port clr_cnt, input, 1, synchronous clear of both counters.
REQ-014 SHALL have port stall_cnt, output, CNT_W, cycles with out_valid=1 and out_ready=0.
REQ-015 SHALL have port bubble_cnt, output, CNT_W, cycles with out_valid=0 and out_ready=1.

Function
REQ-016 SHALL hold two registers, main (drives out_data) and skid, plus state machine EMPTY/BUSY/FULL.
REQ-017 SHALL decode in_ready = (state != FULL) and out_valid = (state != EMPTY) from registers only; no combinational path from out_ready to in_ready or from in_valid to out_valid.
REQ-018 Handshake: a transfer occurs on a side in a cycle where valid and ready are both 1; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-019 EMPTY: in_valid=1 -> main<=in_data, go BUSY; else stay.
REQ-020 BUSY: in_valid=1, out_ready=1 -> main<=in_data, stay BUSY; in_valid=1, out_ready=0 -> skid<=in_data, go FULL; in_valid=0, out_ready=1 -> go EMPTY; else stay.
REQ-021 FULL: in_valid ignored (in_ready=0); out_ready=1 -> main<=skid, go BUSY; else stay.
REQ-022 Latency: one cycle from input transfer to out_valid when EMPTY; sustained throughput one payload per cycle when out_ready=1.
REQ-023 Ordering: payloads SHALL leave in acceptance order; none duplicated or dropped except by flush.
REQ-024 occupancy SHALL equal 0/1/2 for EMPTY/BUSY/FULL.
REQ-025 flush=1 SHALL force next state EMPTY regardless of other inputs; a payload presented with in_valid=1 in the flush cycle is discarded, and nothing reaches downstream in the cycle following the flush.
REQ-026 Counters SHALL increment by one per qualifying cycle, saturate at 2^CNT_W-1 (no wrap), and clear when clr_cnt=1; clr_cnt takes priority over increment.

Reset
REQ-027 rst_n=0 at a clock edge SHALL set state EMPTY, main and skid to 0, out_data=0, out_valid=0, in_ready=1, occupancy=0, both counters 0.
REQ-028 Reset SHALL take priority over flush, clr_cnt and any handshake; reset mid-operation discards all held payloads.
REQ-029 First transfer SHALL be possible in the first cycle after rst_n returns to 1.

Configuration
REQ-030 Macro PIPE_SKID_PERF_CNT_EN defined: stall_cnt and bubble_cnt SHALL be implemented as specified.
REQ-031 Macro PIPE_SKID_PERF_CNT_EN undefined: counter registers SHALL not be built; stall_cnt and bubble_cnt SHALL be constant 0; clr_cnt ignored; all other behaviour unchanged.

Verification
REQ-032 Reset, then in_valid=1 in_data=0x1_0000_0013_0000_0000, out_ready=1 -> out_valid=1 with that payload next cycle, occupancy=1.
REQ-033 Stream 8 payloads 1..8 with out_ready=1 every cycle -> 8 consecutive outputs 1..8, in_ready never 0.
REQ-034 Payloads A,B,C offered while out_ready=0 -> A,B held (occupancy=2, in_ready=0), C held upstream; raise out_ready -> outputs A,B,C in order, out_data stable while stalled.
REQ-035 FULL with A,B, assert flush=1 with in_valid=1 payload C -> next cycle occupancy=0, out_valid=0, A,B,C never output.
REQ-036 With PIPE_SKID_PERF_CNT_EN, CNT_W=4: hold out_valid=1/out_ready=0 for 20 cycles -> stall_cnt=15 (saturated); clr_cnt=1 -> 0; without macro -> stays 0.
REQ-037 Assert rst_n=0 while FULL with flush=1 and clr_cnt=0 -> all outputs at REQ-027 values next cycle.
